memory_dumper: RTL and testbench

//   Read-back counterpart of the program loader: after the CPU halts, sweeps a RAM range
//   and streams each word out on a valid/ready port for the testbench or host to collect.

---
 rtl/memory_dumper_pkg.sv | 7 +
 rtl/memory_dumper.sv | 102 ++++++++++
 tb/tb_memory_dumper.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_dumper_pkg.sv
// Shared sizing for the memory dumper; mirrors the system-wide word and address widths.
package memory_dumper_pkg;

   localparam int WORD_SIZE_DEFAULT     = 16;
   localparam int MEM_ADDR_SIZE_DEFAULT = 8;

endpackage : memory_dumper_pkg

// File: rtl/memory_dumper.sv
// Post-halt RAM read-back engine: sweeps base_addr..base_addr+word_count-1 and streams
// each word on a valid/ready port, owning the RAM address path while busy.
module memory_dumper
   import memory_dumper_pkg::*;
#(
   parameter int WORD_SIZE     = WORD_SIZE_DEFAULT,
   parameter int MEM_ADDR_SIZE = MEM_ADDR_SIZE_DEFAULT
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic [MEM_ADDR_SIZE-1:0] base_addr,
   input  logic [MEM_ADDR_SIZE:0]   word_count,
   output logic [MEM_ADDR_SIZE-1:0] mem_addr,
   input  logic [WORD_SIZE-1:0]     mem_read_data,
   output logic [WORD_SIZE-1:0]     out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_last,
   output logic                     busy,
   output logic                     done
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_READ    = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;
   localparam logic [1:0] ST_SEND    = 2'd3;

   localparam logic [MEM_ADDR_SIZE:0] REMAINING_ONE = {{MEM_ADDR_SIZE{1'b0}}, 1'b1};

   logic [1:0]               state;
   logic [MEM_ADDR_SIZE-1:0] addr_reg;
   logic [MEM_ADDR_SIZE:0]   remaining;

   // The RAM registers its address, so the address register drives it directly and the
   // read data appears one cycle later in CAPTURE.
   assign mem_addr = addr_reg;

   // NOTE: every register here uses <= so all updates take effect together at the edge;
   // a blocking = would let later statements see half-updated state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         addr_reg  <= '0;
         remaining <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  if (word_count == '0) begin
                     done <= 1'b1;
                  end else begin
                     addr_reg  <= base_addr;
                     remaining <= word_count;
                     busy      <= 1'b1;
                     state     <= ST_READ;
                  end
               end
            end

            ST_READ: begin
               state <= ST_CAPTURE;
            end

            ST_CAPTURE: begin
               out_data  <= mem_read_data;
               out_valid <= 1'b1;
               out_last  <= (remaining == REMAINING_ONE);
               state     <= ST_SEND;
            end

            ST_SEND: begin
               // Word and flags stay frozen until the sink takes it; no timeout.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  remaining <= remaining - 1'b1;
                  if (remaining == REMAINING_ONE) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= ST_IDLE;
                  end else begin
                     addr_reg <= addr_reg + 1'b1;
                     state    <= ST_READ;
                  end
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule : memory_dumper

// File: tb/tb_memory_dumper.sv
// Directed bench for memory_dumper: table of dump jobs plus hand sequences for latency,
// backpressure and mid-dump reset, against a registered-read RAM model.
module tb_memory_dumper;

   logic        clock;
   logic        reset;
   logic        start;
   logic [7:0]  base_addr;
   logic [8:0]  word_count;
   logic [7:0]  mem_addr;
   logic [15:0] mem_read_data;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        busy;
   logic        done;

   logic [15:0] ram [256];

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0]  base;
      logic [8:0]  count;
      int          stall;
      bit          hold;
      int          exp_n;
      logic [15:0] exp_first;
      logic [15:0] exp_final;
   } vec_t;

   vec_t vecs [8];

   memory_dumper #(.WORD_SIZE(16), .MEM_ADDR_SIZE(8)) dut (
      .clock         (clock),
      .reset         (reset),
      .start         (start),
      .base_addr     (base_addr),
      .word_count    (word_count),
      .mem_addr      (mem_addr),
      .mem_read_data (mem_read_data),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_last      (out_last),
      .busy          (busy),
      .done          (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) mem_read_data <= ram[mem_addr];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running want finished");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] exp_word(input logic [7:0] a);
      case (a)
         8'h10:   return 16'h00A1;
         8'h11:   return 16'h00B2;
         8'h12:   return 16'h00C3;
         8'h13:   return 16'h00D4;
         default: return {a, ~a};
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Runs one dump job, acting as the sink and checking every word as it is accepted.
   task automatic run_dump(input vec_t v);
      int          nwords, ndone, post, stall_left;
      bit          busy_seen, valid_seen, drop_start, finished;
      logic [15:0] first_w, final_w;
      logic [7:0]  addr;
      nwords = 0; ndone = 0; post = 0; stall_left = v.stall;
      busy_seen = 1'b0; valid_seen = 1'b0; drop_start = 1'b0; finished = 1'b0;
      first_w = '0; final_w = '0;
      base_addr  = v.base;
      word_count = v.count;
      out_ready  = 1'b0;
      start      = 1'b1;
      tick();
      if (v.hold) begin
         base_addr  = 8'h80;
         word_count = 9'd5;
      end else begin
         start = 1'b0;
      end
      for (int cyc = 0; cyc < 1500 && !finished; cyc++) begin
         if (drop_start) start = 1'b0;
         if (busy) busy_seen = 1'b1;
         if (out_valid) valid_seen = 1'b1;
         if (done) ndone++;
         if (ndone > 0) begin
            post++;
            if (post > 3) finished = 1'b1;
         end
         if (stall_left > 0 && stall_left < v.stall)
            check("bp_valid_held", 32'(out_valid), 32'd1);
         out_ready = (stall_left == 0);
         if (out_valid) begin
            addr = v.base + 8'(nwords);
            if (!out_ready) begin
               stall_left--;
               check("bp_data_held", 32'(out_data), 32'(exp_word(addr)));
            end else begin
               check("word_data", 32'(out_data), 32'(exp_word(addr)));
               check("word_addr", 32'(mem_addr), 32'(addr));
               check("word_last", 32'(out_last), 32'(nwords == (int'(v.count) - 1)));
               if (nwords == 0) first_w = out_data;
               final_w = out_data;
               nwords++;
               if (out_last) drop_start = 1'b1;
            end
         end
         if (!finished) tick();
      end
      out_ready = 1'b0;
      start     = 1'b0;
      check("dump_finished", 32'(finished), 32'd1);
      check("dump_words", 32'(nwords), 32'(v.exp_n));
      check("done_pulses", 32'(ndone), 32'd1);
      check("busy_after", 32'(busy), 32'd0);
      check("valid_after", 32'(out_valid), 32'd0);
      check("busy_seen", 32'(busy_seen), 32'(v.count != 9'd0));
      check("valid_seen", 32'(valid_seen), 32'(v.count != 9'd0));
      if (v.exp_n > 0) begin
         check("first_word", 32'(first_w), 32'(v.exp_first));
         check("final_word", 32'(final_w), 32'(v.exp_final));
      end
   endtask

   initial begin
      vec_t fresh;

      for (int i = 0; i < 256; i++) ram[i] = {8'(i), ~8'(i)};
      ram[8'h10] = 16'h00A1;
      ram[8'h11] = 16'h00B2;
      ram[8'h12] = 16'h00C3;
      ram[8'h13] = 16'h00D4;

      //           base   count   stall hold n    first      final
      vecs[0] = '{8'h10, 9'd4,   0,    0,   4,   16'h00A1, 16'h00D4};
      vecs[1] = '{8'h10, 9'd2,   5,    0,   2,   16'h00A1, 16'h00B2};
      vecs[2] = '{8'hFE, 9'd4,   0,    0,   4,   16'hFE01, 16'h01FE};
      vecs[3] = '{8'h00, 9'd256, 0,    0,   256, 16'h00FF, 16'hFF00};
      vecs[4] = '{8'h80, 9'd1,   0,    0,   1,   16'h807F, 16'h807F};
      vecs[5] = '{8'h40, 9'd0,   0,    0,   0,   16'h0000, 16'h0000};
      vecs[6] = '{8'h10, 9'd2,   0,    1,   2,   16'h00A1, 16'h00B2};
      vecs[7] = '{8'hFF, 9'd2,   2,    0,   2,   16'hFF00, 16'h00FF};

      reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b0;
      tick();
      tick();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_last", 32'(out_last), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      reset = 1'b0;
      tick();

      // Latency and spacing with the sink always ready.
      base_addr = 8'h10; word_count = 9'd3; out_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      check("lat_e0_busy", 32'(busy), 32'd1);
      check("lat_e0_addr", 32'(mem_addr), 32'h10);
      check("lat_e0_valid", 32'(out_valid), 32'd0);
      tick();
      check("lat_e1_valid", 32'(out_valid), 32'd0);
      tick();
      check("lat_e2_valid", 32'(out_valid), 32'd1);
      check("lat_e2_data", 32'(out_data), 32'h00A1);
      check("lat_e2_last", 32'(out_last), 32'd0);
      tick();
      check("lat_e3_valid", 32'(out_valid), 32'd0);
      check("lat_e3_addr", 32'(mem_addr), 32'h11);
      tick();
      check("lat_e4_valid", 32'(out_valid), 32'd0);
      tick();
      check("lat_e5_valid", 32'(out_valid), 32'd1);
      check("lat_e5_data", 32'(out_data), 32'h00B2);
      tick();
      check("lat_e6_addr", 32'(mem_addr), 32'h12);
      tick();
      tick();
      check("lat_e8_data", 32'(out_data), 32'h00C3);
      check("lat_e8_last", 32'(out_last), 32'd1);
      tick();
      check("lat_e9_done", 32'(done), 32'd1);
      check("lat_e9_busy", 32'(busy), 32'd0);
      check("lat_e9_valid", 32'(out_valid), 32'd0);
      tick();
      check("lat_e10_done", 32'(done), 32'd0);
      out_ready = 1'b0;
      tick();

      for (int v = 0; v < 8; v++) begin
         run_dump(vecs[v]);
         tick();
      end

      // Reset while a word is stalled in SEND.
      base_addr = 8'h20; word_count = 9'd3; out_ready = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 10 && !out_valid; i++) tick();
      check("rst_mid_pre_valid", 32'(out_valid), 32'd1);
      tick();
      reset = 1'b1;
      tick();
      check("rst_mid_valid", 32'(out_valid), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_addr", 32'(mem_addr), 32'd0);
      check("rst_mid_last", 32'(out_last), 32'd0);
      check("rst_mid_done", 32'(done), 32'd0);
      reset = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rst_quiet_valid", 32'(out_valid), 32'd0);
         check("rst_quiet_busy", 32'(busy), 32'd0);
      end
      out_ready = 1'b0;
      fresh = '{8'h12, 9'd2, 0, 0, 2, 16'h00C3, 16'h00D4};
      run_dump(fresh);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_memory_dumper
